geig_stack_serializer: RTL and testbench

//  Downstream consumer of the 48-bit geiger data stack {counts[15:0], timestamp[23:0], id[7:0]}.

---
 rtl/geig_stack_serializer_pkg.sv | 40 ++++
 rtl/geig_stack_serializer_fifo.sv | 60 ++++++
 rtl/geig_stack_serializer.sv | 150 +++++++++++++++
 tb/tb_geig_stack_serializer.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/geig_stack_serializer_pkg.sv
// Shared definitions for the geiger stack serializer: stack layout, frame constants, FSM states.
// frame_byte() maps a frame byte index to its source field of the buffered stack.
package geig_stack_serializer_pkg;

  localparam int         STACK_W       = 48;
  localparam int         FRAME_LEN     = 8;
  localparam logic [7:0] SYNC_BYTE_DEF = 8'hEB;
  localparam logic [7:0] GEIG_ID_DEF   = 8'h47;

  typedef struct packed {
    logic [15:0] counts;
    logic [23:0] timestamp;
    logic [7:0]  id;
  } stack_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_SEND = 2'd2
  } state_t;

  // Byte 7 (checksum) is not a stack field and is produced by the caller.
  function automatic logic [7:0] frame_byte(input stack_t s, input logic [2:0] idx,
                                            input logic [7:0] sync);
    logic [7:0] b;
    b = 8'h00;
    case (idx)
      3'd0:    b = sync;
      3'd1:    b = s.id;
      3'd2:    b = s.timestamp[23:16];
      3'd3:    b = s.timestamp[15:8];
      3'd4:    b = s.timestamp[7:0];
      3'd5:    b = s.counts[15:8];
      3'd6:    b = s.counts[7:0];
      default: b = 8'h00;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/geig_stack_serializer_fifo.sv
// Synchronous first-word-fall-through FIFO; head visible combinationally on o_pop_dat.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module geig_stack_serializer_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 48
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_push_dat,
  output logic [WIDTH-1:0] o_pop_dat,
  output logic             o_full,
  output logic             o_empty
);

  localparam int          AW       = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full    = (r_count == FULL_CNT);
  assign o_empty   = (r_count == '0);
  assign w_pop     = i_pop & ~o_empty;
  assign w_push    = i_push & (~o_full | w_pop);
  assign o_pop_dat = r_mem[r_rd_ptr];

  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_push_dat;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/geig_stack_serializer.sv
// Geiger stack to 8-byte telemetry frame serializer; first TX_VALID 3 cycles after an idle-time strobe.
// TX_DATA/TX_VALID hold while TX_READY is low; stacks hitting a full FIFO or a foreign id are dropped and counted.
module geig_stack_serializer
  import geig_stack_serializer_pkg::*;
#(
  parameter int         FIFO_DEPTH = 4,
  parameter logic [7:0] SYNC_BYTE  = SYNC_BYTE_DEF,
  parameter logic [7:0] GEIG_ID    = GEIG_ID_DEF
) (
  input  logic               CLK_100KHZ,
  input  logic               RESET,
  input  logic [STACK_W-1:0] G_DATA_STACK,
  input  logic               STACK_VALID,
  input  logic               TX_READY,
  output logic [7:0]         TX_DATA,
  output logic               TX_VALID,
  output logic               BUSY,
  output logic               OVERFLOW,
  output logic               ID_ERROR,
  output logic [7:0]         DROP_COUNT
);

  localparam logic [2:0] LAST_IDX = 3'(FRAME_LEN - 1);
  localparam logic [2:0] CHK_IDX  = 3'(FRAME_LEN - 2);

  state_t             r_state;
  stack_t             r_shadow;
  logic [2:0]         r_idx;
  logic [7:0]         r_chk;
  logic [7:0]         r_tx_data;
  logic               r_tx_vld;
  logic               r_overflow;
  logic               r_id_error;
  logic [7:0]         r_drop_cnt;

  stack_t             w_fifo_dat;
  logic [STACK_W-1:0] w_fifo_rd;
  logic               w_fifo_full;
  logic               w_fifo_empty;
  logic               w_id_ok;
  logic               w_last_xfer;
  logic               w_pop;
  logic               w_push;
  logic               w_ovf_drop;
  logic               w_id_drop;

  assign w_id_ok     = (G_DATA_STACK[7:0] == GEIG_ID);
  assign w_last_xfer = (r_state == ST_SEND) & TX_READY & (r_idx == LAST_IDX);
  // Pop whenever the FSM is about to enter LOAD, so a full FIFO frees a slot the same cycle.
  assign w_pop       = ~w_fifo_empty & ((r_state == ST_IDLE) | w_last_xfer);
  assign w_push      = STACK_VALID & w_id_ok & (~w_fifo_full | w_pop);
  assign w_ovf_drop  = STACK_VALID & w_id_ok & w_fifo_full & ~w_pop;
  assign w_id_drop   = STACK_VALID & ~w_id_ok;
  assign w_fifo_dat  = w_fifo_rd;

  geig_stack_serializer_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (STACK_W)
  ) u_fifo (
    .i_clk      (CLK_100KHZ),
    .i_rst      (RESET),
    .i_push     (w_push),
    .i_pop      (w_pop),
    .i_push_dat (G_DATA_STACK),
    .o_pop_dat  (w_fifo_rd),
    .o_full     (w_fifo_full),
    .o_empty    (w_fifo_empty)
  );

  always_ff @(posedge CLK_100KHZ or posedge RESET) begin
    if (RESET) begin
      r_overflow <= 1'b0;
      r_id_error <= 1'b0;
      r_drop_cnt <= 8'h00;
    end else begin
      if (w_ovf_drop) begin
        r_overflow <= 1'b1;
      end
      if (w_id_drop) begin
        r_id_error <= 1'b1;
      end
      if ((w_ovf_drop | w_id_drop) && (r_drop_cnt != 8'hFF)) begin
        r_drop_cnt <= r_drop_cnt + 8'd1;
      end
    end
  end

  always_ff @(posedge CLK_100KHZ or posedge RESET) begin
    if (RESET) begin
      r_state   <= ST_IDLE;
      r_shadow  <= '0;
      r_idx     <= 3'd0;
      r_chk     <= 8'h00;
      r_tx_data <= 8'h00;
      r_tx_vld  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (!w_fifo_empty) begin
            r_state  <= ST_LOAD;
            r_shadow <= w_fifo_dat;
            r_chk    <= 8'h00;
          end
        end
        ST_LOAD: begin
          r_state   <= ST_SEND;
          r_idx     <= 3'd0;
          r_tx_vld  <= 1'b1;
          r_tx_data <= SYNC_BYTE;
        end
        ST_SEND: begin
          if (TX_READY) begin
            if ((r_idx != 3'd0) && (r_idx != LAST_IDX)) begin
              r_chk <= r_chk ^ r_tx_data;
            end
            if (r_idx == LAST_IDX) begin
              r_tx_vld  <= 1'b0;
              r_tx_data <= 8'h00;
              r_idx     <= 3'd0;
              if (!w_fifo_empty) begin
                r_state  <= ST_LOAD;
                r_shadow <= w_fifo_dat;
                r_chk    <= 8'h00;
              end else begin
                r_state <= ST_IDLE;
              end
            end else begin
              r_idx <= r_idx + 3'd1;
              // Last data byte is leaving now, so fold it in to form the checksum byte.
              r_tx_data <= (r_idx == CHK_IDX) ? (r_chk ^ r_tx_data)
                                              : frame_byte(r_shadow, r_idx + 3'd1, SYNC_BYTE);
            end
          end
        end
        default: begin
          r_state  <= ST_IDLE;
          r_tx_vld <= 1'b0;
        end
      endcase
    end
  end

  assign TX_DATA    = r_tx_data;
  assign TX_VALID   = r_tx_vld;
  assign BUSY       = (r_state != ST_IDLE) | ~w_fifo_empty;
  assign OVERFLOW   = r_overflow;
  assign ID_ERROR   = r_id_error;
  assign DROP_COUNT = r_drop_cnt;

endmodule

// File: tb/tb_geig_stack_serializer.sv
// Directed bench for geig_stack_serializer: latency, stalls, overflow, id reject, pop/push on full, reset abort.
module tb_geig_stack_serializer;

  logic        clk = 1'b0;
  logic        RESET = 1'b1;
  logic [47:0] G_DATA_STACK = '0;
  logic        STACK_VALID = 1'b0;
  logic        TX_READY = 1'b0;
  logic [7:0]  TX_DATA;
  logic        TX_VALID;
  logic        BUSY;
  logic        OVERFLOW;
  logic        ID_ERROR;
  logic [7:0]  DROP_COUNT;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [7:0]  rxq[$];
  logic [63:0] f;
  logic        prev_stall;
  logic [7:0]  prev_dat;

  always #5 clk = ~clk;

  geig_stack_serializer dut (
    .CLK_100KHZ   (clk),
    .RESET        (RESET),
    .G_DATA_STACK (G_DATA_STACK),
    .STACK_VALID  (STACK_VALID),
    .TX_READY     (TX_READY),
    .TX_DATA      (TX_DATA),
    .TX_VALID     (TX_VALID),
    .BUSY         (BUSY),
    .OVERFLOW     (OVERFLOW),
    .ID_ERROR     (ID_ERROR),
    .DROP_COUNT   (DROP_COUNT)
  );

  // Bytes are stable from just after one edge to the next, so capture mid-cycle.
  always @(negedge clk) begin
    if (!RESET && TX_VALID && TX_READY) rxq.push_back(TX_DATA);
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    STACK_VALID = 1'b0;
    TX_READY = 1'b0;
    tick(2);
    RESET = 1'b0;
    rxq.delete();
    tick(1);
  endtask

  task automatic send_stack(input logic [47:0] s);
    G_DATA_STACK = s;
    STACK_VALID = 1'b1;
    tick(1);
    STACK_VALID = 1'b0;
    G_DATA_STACK = '0;
  endtask

  task automatic wait_bytes(input int n, input int budget, input string tag);
    for (int i = 0; i < budget && rxq.size() < n; i++) tick(1);
    check_eq(tag, 64'(rxq.size()), 64'(n));
  endtask

  task automatic pop_frame(output logic [63:0] fr);
    fr = '0;
    for (int i = 0; i < 8; i++) begin
      if (rxq.size() > 0) fr = {fr[55:0], rxq.pop_front()};
    end
  endtask

  function automatic logic [63:0] exp_frame(input logic [47:0] s);
    logic [7:0] b [8];
    b[0] = 8'hEB;
    b[1] = s[7:0];
    b[2] = s[31:24];
    b[3] = s[23:16];
    b[4] = s[15:8];
    b[5] = s[47:40];
    b[6] = s[39:32];
    b[7] = b[1] ^ b[2] ^ b[3] ^ b[4] ^ b[5] ^ b[6];
    return {b[0], b[1], b[2], b[3], b[4], b[5], b[6], b[7]};
  endfunction

  function automatic logic [47:0] stk(input int i);
    return {16'hC000 + 16'(i), 24'h7A0000 + 24'(i * 3), 8'h47};
  endfunction

  initial begin
    tick(2);
    RESET = 1'b0;
    tick(1);
    check_eq("rst_tx_valid", 64'(TX_VALID), 64'd0);
    check_eq("rst_tx_data", 64'(TX_DATA), 64'd0);
    check_eq("rst_busy", 64'(BUSY), 64'd0);
    check_eq("rst_overflow", 64'(OVERFLOW), 64'd0);
    check_eq("rst_id_error", 64'(ID_ERROR), 64'd0);
    check_eq("rst_drop_count", 64'(DROP_COUNT), 64'd0);

    // Single frame, no stall. CHK = 47^AB^CD^EF^01^23 = EC.
    TX_READY = 1'b1;
    send_stack(48'h0123_ABCDEF_47);
    check_eq("t1_lat1_valid", 64'(TX_VALID), 64'd0);
    check_eq("t1_busy", 64'(BUSY), 64'd1);
    tick(1);
    check_eq("t1_lat2_valid", 64'(TX_VALID), 64'd0);
    tick(1);
    check_eq("t1_lat3_valid", 64'(TX_VALID), 64'd1);
    check_eq("t1_first_byte", 64'(TX_DATA), 64'hEB);
    wait_bytes(8, 30, "t1_bytes");
    pop_frame(f);
    check_eq("t1_frame", f, 64'hEB47_ABCD_EF01_23EC);
    tick(2);
    check_eq("t1_busy_done", 64'(BUSY), 64'd0);

    // Ready high one cycle in three.
    TX_READY = 1'b0;
    send_stack(48'h0123_ABCDEF_47);
    prev_stall = 1'b0;
    prev_dat = 8'h00;
    for (int k = 0; k < 120 && rxq.size() < 8; k++) begin
      tick(1);
      if (prev_stall) begin
        check_eq("t2_hold_valid", 64'(TX_VALID), 64'd1);
        check_eq("t2_hold_data", 64'(TX_DATA), 64'(prev_dat));
      end
      TX_READY = (k % 3 == 2);
      prev_stall = TX_VALID & ~TX_READY;
      prev_dat = TX_DATA;
    end
    TX_READY = 1'b1;
    check_eq("t2_bytes", 64'(rxq.size()), 64'd8);
    pop_frame(f);
    check_eq("t2_frame", f, 64'hEB47_ABCD_EF01_23EC);

    // Seven back-to-back stacks with downstream stalled: one in the shadow, four buffered, two dropped.
    do_reset();
    for (int i = 0; i < 7; i++) begin
      G_DATA_STACK = stk(i);
      STACK_VALID = 1'b1;
      tick(1);
    end
    STACK_VALID = 1'b0;
    tick(2);
    check_eq("t3_overflow", 64'(OVERFLOW), 64'd1);
    check_eq("t3_drop_count", 64'(DROP_COUNT), 64'd2);
    check_eq("t3_id_error", 64'(ID_ERROR), 64'd0);
    check_eq("t3_stall_valid", 64'(TX_VALID), 64'd1);
    check_eq("t3_stall_data", 64'(TX_DATA), 64'hEB);
    TX_READY = 1'b1;
    wait_bytes(40, 300, "t3_bytes");
    for (int i = 0; i < 5; i++) begin
      pop_frame(f);
      check_eq("t3_frame", f, exp_frame(stk(i)));
    end
    tick(3);
    check_eq("t3_busy_done", 64'(BUSY), 64'd0);

    // Foreign id is rejected.
    do_reset();
    TX_READY = 1'b1;
    send_stack(48'h5555_123456_00);
    tick(10);
    check_eq("t4_no_bytes", 64'(rxq.size()), 64'd0);
    check_eq("t4_id_error", 64'(ID_ERROR), 64'd1);
    check_eq("t4_drop_count", 64'(DROP_COUNT), 64'd1);
    check_eq("t4_overflow", 64'(OVERFLOW), 64'd0);
    check_eq("t4_busy", 64'(BUSY), 64'd0);

    // Full FIFO, strobe on the cycle the last byte transfers (pop cycle).
    do_reset();
    for (int i = 0; i < 5; i++) begin
      G_DATA_STACK = stk(16 + i);
      STACK_VALID = 1'b1;
      tick(1);
    end
    STACK_VALID = 1'b0;
    tick(4);
    check_eq("t5_fill_overflow", 64'(OVERFLOW), 64'd0);
    check_eq("t5_fill_drop", 64'(DROP_COUNT), 64'd0);
    TX_READY = 1'b1;
    tick(7);
    check_eq("t5_chk_byte", 64'(TX_DATA), 64'(exp_frame(stk(16)) & 64'hFF));
    send_stack(stk(21));
    check_eq("t5_overflow", 64'(OVERFLOW), 64'd0);
    check_eq("t5_drop_count", 64'(DROP_COUNT), 64'd0);
    wait_bytes(48, 300, "t5_bytes");
    for (int i = 0; i < 6; i++) begin
      pop_frame(f);
      check_eq("t5_frame", f, exp_frame(stk(16 + i)));
    end

    // Reset after byte 3 aborts the frame; the next stack starts cleanly from sync.
    do_reset();
    TX_READY = 1'b1;
    send_stack(48'h0F0F_010203_47);
    wait_bytes(4, 30, "t6_partial_bytes");
    RESET = 1'b1;
    #1;
    check_eq("t6_rst_valid", 64'(TX_VALID), 64'd0);
    check_eq("t6_rst_data", 64'(TX_DATA), 64'd0);
    check_eq("t6_rst_busy", 64'(BUSY), 64'd0);
    check_eq("t6_rst_drop", 64'(DROP_COUNT), 64'd0);
    tick(2);
    RESET = 1'b0;
    rxq.delete();
    tick(4);
    check_eq("t6_no_resume", 64'(rxq.size()), 64'd0);
    check_eq("t6_idle_busy", 64'(BUSY), 64'd0);
    send_stack(48'hBEEF_445566_47);
    wait_bytes(8, 30, "t6_bytes");
    pop_frame(f);
    check_eq("t6_frame", f, exp_frame(48'hBEEF_445566_47));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
